seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_pkg.sv | 29 ++
 rtl/seven_seg_scanner_if.sv | 13 +
 rtl/seven_seg_scanner_slot_timer.sv | 32 +++
 rtl/seven_seg_scanner.sv | 97 +++++++++
 tb/tb_seven_seg_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the digit scanner and the segment-decode side:
// active-low anode strobes, digit index type and scan phase encoding.
package seven_seg_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [3:0] ANODE_D0  = 4'b1110;
    localparam logic [3:0] ANODE_D1  = 4'b1101;
    localparam logic [3:0] ANODE_D2  = 4'b1011;
    localparam logic [3:0] ANODE_D3  = 4'b0111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = ANODE_D0;
            2'd1:    a = ANODE_D1;
            2'd2:    a = ANODE_D2;
            default: a = ANODE_D3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle: digit enables in, anode strobes / slot index / frame pulse out.
interface seven_seg_scanner_if;
    import seven_seg_pkg::*;

    logic [3:0] digit_en;
    logic [3:0] anode;
    digit_idx_t digit_sel;
    logic       frame_done;

    modport master (input digit_en, output anode, digit_sel, frame_done);
    modport slave  (output digit_en, input anode, digit_sel, frame_done);

endinterface

// File: rtl/seven_seg_scanner_slot_timer.sv
// Per-slot wrap counter: cnt runs 0..REFRESH_CYCLES-1, with a wrap pulse on the
// last count and a flag on the last blank count.
module slot_timer #(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          blank_end
);

    localparam logic [CW-1:0] LAST       = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    assign wrap = (cnt == LAST);
    // With no blank window the flag must never fire (BLANK_LAST would alias all-ones).
    assign blank_end = (BLANK_CYCLES != 0) && (cnt == BLANK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display scanner: fixed-length slots, an anti-ghosting
// blank at the start of each slot, registered one-cold anode strobes.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                reset,
    seven_seg_scanner_if.master bus
);

    localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
    // Without a blank window the phase starts (and stays) in DRIVE.
    localparam scan_state_t ST_INIT = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          blank_end;
    digit_idx_t    idx;
    logic [3:0]    en_q;
    scan_state_t   state;
    scan_state_t   state_n;
    logic [3:0]    anode_d;
    logic          frame_last;

    slot_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES),
        .BLANK_CYCLES   (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .cnt       (cnt),
        .wrap      (wrap),
        .blank_end (blank_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            en_q <= '0;
        end else begin
            en_q <= bus.digit_en;
            if (wrap) begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        anode_d = ANODE_OFF;
        case (state)
            ST_BLANK: begin
                if (blank_end) begin
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (en_q[idx]) begin
                    anode_d = anode_for(idx);
                end
                if (wrap && (BLANK_CYCLES != 0)) begin
                    state_n = ST_BLANK;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    assign frame_last = (idx == 2'd3) && (cnt == LAST);

    // Outputs show the slot state of the previous cycle; anode is decoded from a
    // single idx so it can never carry two zeros, even as idx advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.anode      <= ANODE_OFF;
            bus.digit_sel  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.anode      <= anode_d;
            bus.digit_sel  <= idx;
            bus.frame_done <= frame_last;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at REFRESH_CYCLES=8 with BLANK_CYCLES=2 and 0.
module tb_seven_seg_scanner;
    import seven_seg_pkg::*;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seven_seg_scanner_if bus_a ();
    seven_seg_scanner_if bus_b ();

    seven_seg_scanner #(.REFRESH_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.master)
    );

    seven_seg_scanner #(.REFRESH_CYCLES(8), .BLANK_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.master)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  en;
        logic [3:0]  anode;
        logic [1:0]  sel;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int unsigned cyc, input logic [3:0] en,
                                input logic [3:0] an, input logic [1:0] sel, input logic fd);
        vec_t v;
        v.cyc = cyc; v.en = en; v.anode = an; v.sel = sel; v.fd = fd;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] an, input logic [1:0] sel,
                         input logic fd, input logic [3:0] want_an, input logic [1:0] want_sel,
                         input logic want_fd);
        checks++;
        if (an !== want_an || sel !== want_sel || fd !== want_fd) begin
            failures++;
            $display("FAIL %s: got anode=%b sel=%0d fd=%b, want anode=%b sel=%0d fd=%b",
                     name, an, sel, fd, want_an, want_sel, want_fd);
        end
    endtask

    task automatic check_a(input string name, input logic [3:0] want_an,
                           input logic [1:0] want_sel, input logic want_fd);
        check(name, bus_a.anode, bus_a.digit_sel, bus_a.frame_done, want_an, want_sel, want_fd);
    endtask

    // Leaves the bench just after the last reset edge; the next tick lands after c0.
    task automatic start_a(input logic [3:0] en);
        rst_a = 1'b1;
        bus_a.digit_en = en;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    // Per-cycle invariants: at most one lit digit, frame pulses exactly 32 cycles apart.
    int unsigned gap_a = 0, gap_b = 0;
    bit          prev_a = 1'b0, prev_b = 1'b0;

    task automatic monitor(input string nm, input logic [3:0] an, input logic fd, input logic rst,
                           inout int unsigned gap, inout bit prev);
        checks++;
        assert ($countones(~an) <= 1) else begin
            failures++;
            $display("FAIL onecold_%s: got anode=%b, want at most one zero bit", nm, an);
        end
        if (rst) begin
            prev = 1'b0;
            gap  = 0;
        end else if (fd === 1'b1) begin
            if (prev) begin
                checks++;
                if (gap != 31) begin
                    failures++;
                    $display("FAIL frame_gap_%s: got %0d cycles between pulses, want 32", nm, gap + 1);
                end
            end
            prev = 1'b1;
            gap  = 0;
        end else begin
            gap++;
            if (prev && gap > 31) begin
                checks++;
                failures++;
                $display("FAIL frame_missing_%s: got no pulse for %0d cycles, want one every 32", nm, gap);
                prev = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor("a", bus_a.anode, bus_a.frame_done, rst_a, gap_a, prev_a);
        monitor("b", bus_b.anode, bus_b.frame_done, rst_b, gap_b, prev_b);
    end

    initial begin
        logic [3:0] onecold [4];
        onecold[0] = 4'b1110; onecold[1] = 4'b1101;
        onecold[2] = 4'b1011; onecold[3] = 4'b0111;

        bus_a.digit_en = 4'b1111;
        bus_b.digit_en = 4'b1111;

        add( 0, 4'b1111, 4'b1111, 2'd0, 1'b0);
        add( 1, 4'b1111, 4'b1111, 2'd0, 1'b0);
        add( 2, 4'b1111, 4'b1110, 2'd0, 1'b0);
        add( 7, 4'b1111, 4'b1110, 2'd0, 1'b0);
        add( 8, 4'b1111, 4'b1111, 2'd1, 1'b0);
        add( 9, 4'b1111, 4'b1111, 2'd1, 1'b0);
        add(10, 4'b1111, 4'b1101, 2'd1, 1'b0);
        add(15, 4'b1111, 4'b1101, 2'd1, 1'b0);
        add(16, 4'b1111, 4'b1111, 2'd2, 1'b0);
        add(18, 4'b1111, 4'b1011, 2'd2, 1'b0);
        add(23, 4'b1111, 4'b1011, 2'd2, 1'b0);
        add(26, 4'b1111, 4'b0111, 2'd3, 1'b0);
        add(30, 4'b1111, 4'b0111, 2'd3, 1'b0);
        add(31, 4'b1111, 4'b0111, 2'd3, 1'b1);
        add(32, 4'b1111, 4'b1111, 2'd0, 1'b0);
        add(34, 4'b1111, 4'b1110, 2'd0, 1'b0);
        add( 2, 4'b1010, 4'b1111, 2'd0, 1'b0);
        add( 7, 4'b1010, 4'b1111, 2'd0, 1'b0);
        add( 9, 4'b1010, 4'b1111, 2'd1, 1'b0);
        add(10, 4'b1010, 4'b1101, 2'd1, 1'b0);
        add(15, 4'b1010, 4'b1101, 2'd1, 1'b0);
        add(18, 4'b1010, 4'b1111, 2'd2, 1'b0);
        add(26, 4'b1010, 4'b0111, 2'd3, 1'b0);
        add(31, 4'b1010, 4'b0111, 2'd3, 1'b1);
        add(33, 4'b1010, 4'b1111, 2'd0, 1'b0);
        add(40, 4'b1010, 4'b1111, 2'd1, 1'b0);
        add(42, 4'b1010, 4'b1101, 2'd1, 1'b0);
        add( 2, 4'b0000, 4'b1111, 2'd0, 1'b0);
        add(31, 4'b0000, 4'b1111, 2'd3, 1'b1);
        add(18, 4'b0100, 4'b1011, 2'd2, 1'b0);
        add(10, 4'b0100, 4'b1111, 2'd1, 1'b0);

        // Reset state
        tick();
        tick();
        check_a("reset_vals", 4'b1111, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            start_a(vecs[i].en);
            repeat (vecs[i].cyc + 1) tick();
            check_a($sformatf("vec%0d_en%b_c%0d", i, vecs[i].en, vecs[i].cyc),
                    vecs[i].anode, vecs[i].sel, vecs[i].fd);
        end

        // Mid-slot disable of digit0: enable seen at edge 4 takes effect at c5
        start_a(4'b1111);
        repeat (4) tick();
        check_a("dis_c3", 4'b1110, 2'd0, 1'b0);
        bus_a.digit_en = 4'b1110;
        tick();
        check_a("dis_c4", 4'b1110, 2'd0, 1'b0);
        tick();
        check_a("dis_c5", 4'b1111, 2'd0, 1'b0);
        repeat (2) tick();
        check_a("dis_c7", 4'b1111, 2'd0, 1'b0);
        tick();
        check_a("dis_c8", 4'b1111, 2'd1, 1'b0);
        repeat (2) tick();
        check_a("dis_c10", 4'b1101, 2'd1, 1'b0);

        // Reset pulse sampled at edge 13
        start_a(4'b1111);
        repeat (13) tick();
        check_a("rst_c12", 4'b1101, 2'd1, 1'b0);
        rst_a = 1'b1;
        tick();
        check_a("rst_c13", 4'b1111, 2'd0, 1'b0);
        rst_a = 1'b0;
        tick();
        check_a("rst_post_c0", 4'b1111, 2'd0, 1'b0);
        tick();
        check_a("rst_post_c1", 4'b1111, 2'd0, 1'b0);
        tick();
        check_a("rst_post_c2", 4'b1110, 2'd0, 1'b0);
        repeat (5) tick();
        check_a("rst_post_c7", 4'b1110, 2'd0, 1'b0);
        tick();
        check_a("rst_post_c8", 4'b1111, 2'd1, 1'b0);
        repeat (23) tick();
        check_a("rst_post_c31", 4'b0111, 2'd3, 1'b1);

        // No blank window: every slot lit from its first clock
        rst_b = 1'b1;
        bus_b.digit_en = 4'b1111;
        tick();
        tick();
        rst_b = 1'b0;
        tick();
        for (int k = 1; k < 40; k++) begin
            tick();
            check($sformatf("noblank_c%0d", k), bus_b.anode, bus_b.digit_sel, bus_b.frame_done,
                  onecold[(k / 8) % 4], 2'((k / 8) % 4), (k % 32) == 31);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
